// File: rtl/config_pkg.sv
// Shared audio-path configuration: sample width, period counter width and
// the percentage type used by analysis blocks.
package CONFIG;
  localparam int AUDIO_BIT_WIDTH = 16;
  localparam int PERIOD_WIDTH    = 8;

  typedef logic [6:0] percent_t;
endpackage

// File: rtl/period_detector_pkg.sv
// Types and constants private to the period detector and its duty divider.
package period_detector_pkg;
  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DIVIDE
  } detector_state_t;

  localparam int unsigned DUTY_SCALE        = 100;
  localparam int unsigned DIVIDE_ITERATIONS = 7;
endpackage

// File: rtl/period_detector_duty_divider.sv
// Serial restoring divider: 7-bit quotient of numerator/denominator, one
// quotient bit per cycle, with an abort that discards the run silently.
module duty_divider
  import period_detector_pkg::*;
#(
  parameter int PERIOD_WIDTH = CONFIG::PERIOD_WIDTH
) (
  input  logic                    clock_50_000_000,
  input  logic                    reset,
  input  logic                    abort,
  input  logic                    start,
  input  logic [PERIOD_WIDTH+6:0] numerator,
  input  logic [PERIOD_WIDTH-1:0] denominator,
  output logic                    busy,
  output logic                    done,
  output CONFIG::percent_t        quotient
);
  localparam int NUM_WIDTH = PERIOD_WIDTH + 7;

  logic [NUM_WIDTH-1:0] remainder;
  logic [NUM_WIDTH-1:0] divisor;
  logic [NUM_WIDTH:0]   trial;
  logic                 fits;
  logic [6:0]           partial;
  logic [6:0]           partial_next;
  logic [2:0]           iterations_left;

  always_comb begin
    trial        = {1'b0, remainder} - {1'b0, divisor};
    fits         = ~trial[NUM_WIDTH];
    partial_next = {partial[5:0], fits};
  end

  // The quotient never exceeds 127 because numerator <= 100*denominator, so
  // the divisor starts aligned at bit 6 and walks down one bit per cycle.
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      quotient        <= '0;
      remainder       <= '0;
      divisor         <= '0;
      partial         <= '0;
      iterations_left <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
      end else if (start) begin
        remainder       <= numerator;
        divisor         <= {1'b0, denominator, 6'b0};
        partial         <= '0;
        iterations_left <= 3'(DIVIDE_ITERATIONS);
        busy            <= 1'b1;
      end else if (busy) begin
        if (fits) remainder <= trial[NUM_WIDTH-1:0];
        divisor         <= divisor >> 1;
        partial         <= partial_next;
        iterations_left <= iterations_left - 3'd1;
        if (iterations_left == 3'd1) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          quotient <= partial_next;
        end
      end
    end
  end

  start_while_idle: assert property (@(posedge clock_50_000_000) disable iff (reset)
    start |-> !busy);

endmodule

// File: rtl/period_detector.sv
// Recovers period (in valid samples) and duty cycle (percent) of an audio
// stream using a hysteretic comparator, edge-to-edge counters and a divider.
module period_detector
  import period_detector_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH = CONFIG::AUDIO_BIT_WIDTH,
  parameter int PERIOD_WIDTH    = CONFIG::PERIOD_WIDTH,
  parameter int HYSTERESIS      = 16
) (
  input  logic                       clock_50_000_000,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       sample_valid,
  input  logic [AUDIO_BIT_WIDTH-1:0] sample,
  output logic [PERIOD_WIDTH-1:0]    period,
  output CONFIG::percent_t           duty_cycle,
  output logic                       result_valid,
  output logic                       locked,
  output logic                       overrun
);
  localparam longint SAMPLE_MAX = (longint'(1) << AUDIO_BIT_WIDTH) - 1;
  localparam longint MIDPOINT   = longint'(1) << (AUDIO_BIT_WIDTH - 1);
  localparam longint HIGH_RAW   = MIDPOINT + longint'(HYSTERESIS);
  localparam longint LOW_RAW    = MIDPOINT - longint'(HYSTERESIS);

  localparam logic [AUDIO_BIT_WIDTH-1:0] THRESHOLD_HIGH =
    AUDIO_BIT_WIDTH'((HIGH_RAW > SAMPLE_MAX) ? SAMPLE_MAX : HIGH_RAW);
  localparam logic [AUDIO_BIT_WIDTH-1:0] THRESHOLD_LOW =
    AUDIO_BIT_WIDTH'((LOW_RAW < longint'(0)) ? longint'(0) : LOW_RAW);

  // One below all-ones: the increment that would land on all-ones is the timeout.
  localparam logic [PERIOD_WIDTH-1:0] COUNT_LIMIT = {{(PERIOD_WIDTH-1){1'b1}}, 1'b0};

  detector_state_t           state;
  logic                      level;
  logic                      level_next;
  logic                      rise;
  logic                      timeout;
  logic [PERIOD_WIDTH-1:0]   sample_count;
  logic [PERIOD_WIDTH-1:0]   high_count;
  logic [PERIOD_WIDTH-1:0]   latched_period;
  logic [PERIOD_WIDTH+6:0]   scaled_high;
  logic                      div_start;
  logic                      div_abort;
  logic                      div_busy;
  logic                      div_done;
  CONFIG::percent_t          div_quotient;

  always_comb begin
    level_next = level;
    if (sample_valid) begin
      level_next = level ? (sample >= THRESHOLD_LOW) : (sample >= THRESHOLD_HIGH);
    end
    rise        = sample_valid & ~level & level_next;
    timeout     = sample_valid & ~rise & (state != IDLE) & (sample_count == COUNT_LIMIT);
    div_start   = rise & (state == MEASURE) & ~div_busy & ~clear;
    div_abort   = clear | timeout;
    scaled_high = ({7'b0, high_count} << 6) + ({7'b0, high_count} << 5)
                + ({7'b0, high_count} << 2);
  end

  duty_divider #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_duty_divider (
    .clock_50_000_000(clock_50_000_000),
    .reset           (reset),
    .abort           (div_abort),
    .start           (div_start),
    .numerator       (scaled_high),
    .denominator     (sample_count),
    .busy            (div_busy),
    .done            (div_done),
    .quotient        (div_quotient)
  );

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state          <= IDLE;
      level          <= 1'b0;
      sample_count   <= '0;
      high_count     <= '0;
      latched_period <= '0;
      period         <= '0;
      duty_cycle     <= '0;
      result_valid   <= 1'b0;
      locked         <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      if (clear) begin
        state        <= IDLE;
        level        <= 1'b0;
        sample_count <= '0;
        high_count   <= '0;
        locked       <= 1'b0;
      end else begin
        level <= level_next;
        if (timeout) begin
          state        <= IDLE;
          sample_count <= '0;
          high_count   <= '0;
          locked       <= 1'b0;
        end else begin
          // Edge handling and divider completion are independent: an edge
          // landing on the completion cycle is both an overrun and a result.
          if (rise) begin
            sample_count <= PERIOD_WIDTH'(1);
            high_count   <= PERIOD_WIDTH'(1);
            unique case (state)
              IDLE:    state <= MEASURE;
              MEASURE: begin
                latched_period <= sample_count;
                state          <= DIVIDE;
              end
              DIVIDE:  overrun <= 1'b1;
              default: state <= IDLE;
            endcase
          end else if (sample_valid && state != IDLE) begin
            sample_count <= sample_count + 1'b1;
            high_count   <= high_count + PERIOD_WIDTH'(level_next);
          end
          if (state == DIVIDE && div_done) begin
            period       <= latched_period;
            duty_cycle   <= div_quotient;
            result_valid <= 1'b1;
            locked       <= 1'b1;
            state        <= MEASURE;
          end
        end
      end
    end
  end

  done_only_in_divide: assert property (@(posedge clock_50_000_000) disable iff (reset)
    div_done |-> state == DIVIDE);
  duty_in_range: assert property (@(posedge clock_50_000_000) disable iff (reset)
    duty_cycle <= CONFIG::percent_t'(DUTY_SCALE));
  result_implies_locked: assert property (@(posedge clock_50_000_000) disable iff (reset)
    result_valid |-> locked);

endmodule

// File: tb/tb_period_detector.sv
// Bench for period_detector: queue-free result model checked every cycle,
// plus hand-computed checkpoints after each directed stimulus phase.
module tb_period_detector;
  localparam int W     = CONFIG::AUDIO_BIT_WIDTH;
  localparam int PW    = CONFIG::PERIOD_WIDTH;
  localparam int LIMIT = (1 << PW) - 1;
  localparam int MIDV  = 1 << (W - 1);
  localparam int TH_HI = MIDV + 16;
  localparam int TH_LO = MIDV - 16;

  logic                 clock_50_000_000 = 1'b0;
  logic                 reset;
  logic                 clear;
  logic                 sample_valid;
  logic [W-1:0]         sample;
  logic [PW-1:0]        period;
  CONFIG::percent_t     duty_cycle;
  logic                 result_valid;
  logic                 locked;
  logic                 overrun;

  int tests = 0;
  int fails = 0;
  int rv_count = 0;
  int ov_count = 0;

  always #5 clock_50_000_000 = ~clock_50_000_000;

  period_detector #(
    .AUDIO_BIT_WIDTH(W),
    .PERIOD_WIDTH   (PW),
    .HYSTERESIS     (16)
  ) dut (
    .clock_50_000_000(clock_50_000_000),
    .reset           (reset),
    .clear           (clear),
    .sample_valid    (sample_valid),
    .sample          (sample),
    .period          (period),
    .duty_cycle      (duty_cycle),
    .result_valid    (result_valid),
    .locked          (locked),
    .overrun         (overrun)
  );

  // Model: signal level, sample/high tallies since the last rising edge, and
  // at most one pending result due 8 input-cycles after its edge.
  int  cyc = 0;
  bit  model_live = 0;
  bit  m_hi, m_meas, m_new, m_rise, pend;
  int  m_cnt, m_hcnt, pend_due, pend_p, pend_d;
  int  e_period, e_duty;
  bit  e_locked, e_rv, e_ov;

  always @(posedge clock_50_000_000) begin
    e_rv = 0;
    e_ov = 0;
    if (reset) begin
      m_hi = 0; m_meas = 0; m_cnt = 0; m_hcnt = 0; pend = 0;
      e_period = 0; e_duty = 0; e_locked = 0;
    end else if (clear) begin
      m_hi = 0; m_meas = 0; m_cnt = 0; m_hcnt = 0; pend = 0;
      e_locked = 0;
    end else begin
      if (sample_valid) begin
        m_new  = m_hi ? (int'(sample) >= TH_LO) : (int'(sample) >= TH_HI);
        m_rise = !m_hi && m_new;
        m_hi   = m_new;
        if (!m_meas) begin
          if (m_rise) begin m_meas = 1; m_cnt = 1; m_hcnt = 1; end
        end else if (m_rise) begin
          if (pend) e_ov = 1;
          else begin
            pend = 1; pend_due = cyc + 8; pend_p = m_cnt; pend_d = (m_hcnt * 100) / m_cnt;
          end
          m_cnt = 1; m_hcnt = 1;
        end else if (m_cnt + 1 == LIMIT) begin
          m_meas = 0; m_cnt = 0; m_hcnt = 0; pend = 0; e_locked = 0;
        end else begin
          m_cnt++;
          if (m_hi) m_hcnt++;
        end
      end
      if (pend && pend_due == cyc) begin
        pend = 0; e_period = pend_p; e_duty = pend_d; e_locked = 1; e_rv = 1;
      end
    end
    cyc++;
    model_live = 1;
  end

  logic [17:0] act_vec, exp_vec;
  always @(negedge clock_50_000_000) begin
    if (model_live) begin
      act_vec = {result_valid, overrun, locked, period, duty_cycle};
      exp_vec = {e_rv, e_ov, e_locked, PW'(e_period), 7'(e_duty)};
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        $display("FAIL cycle_compare @%0d: {rv,ov,lock,period,duty} got %b/%b/%b/%0d/%0d required %b/%b/%b/%0d/%0d",
                 cyc, result_valid, overrun, locked, period, duty_cycle,
                 e_rv, e_ov, e_locked, e_period, e_duty);
      end
      if (result_valid === 1'b1) rv_count++;
      if (overrun === 1'b1) ov_count++;
    end
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] s);
    sample_valid = v;
    sample       = s;
    @(posedge clock_50_000_000);
    #1;
  endtask

  task automatic square(input int hi_n, input int lo_n, input int reps);
    for (int r = 0; r < reps; r++) begin
      repeat (hi_n) drive(1'b1, '1);
      repeat (lo_n) drive(1'b1, '0);
    end
  endtask

  task automatic check_result(input string name, input int p, input int d);
    check({name, "_period"}, period, p);
    check({name, "_duty"}, duty_cycle, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; clear = 1'b0; sample_valid = 1'b0; sample = '0;
    drive(1'b0, '0);
    drive(1'b0, '0);
    reset = 1'b0;
    drive(1'b0, '0);
    check("reset_period", period, 0);
    check("reset_duty", duty_cycle, 0);
    check("reset_flags", {result_valid, locked, overrun}, 0);

    // 5/5 square: edges at 0,10,20,30 -> results at 19,29,39
    rv_count = 0; ov_count = 0;
    square(5, 5, 4);
    check("sq10_results", rv_count, 3);
    check("sq10_overrun", ov_count, 0);
    check("sq10_locked", locked, 1);
    check_result("sq10", 10, 50);

    square(5, 15, 4);
    check_result("sq20_25", 20, 25);
    square(7, 13, 3);
    check_result("sq20_35", 20, 35);

    // Period 3 is shorter than the divide latency: edges 3 and 6 after each
    // accepted edge are dropped.
    ov_count = 0;
    square(1, 2, 7);
    check("p3_overruns", ov_count, 4);
    check_result("p3", 3, 33);

    for (int r = 0; r < 5; r++) begin
      repeat (3) drive(1'b1, '1);
      for (int k = 0; k < 3; k++) drive(1'b1, (k % 2 == 0) ? 16'h800A : 16'h7FF6);
      repeat (3) drive(1'b1, '0);
      for (int k = 0; k < 3; k++) drive(1'b1, (k % 2 == 0) ? 16'h800A : 16'h7FF6);
    end
    check_result("noisy", 12, 50);

    for (int r = 0; r < 4; r++) begin
      repeat (5) begin drive(1'b1, '1); drive(1'b0, '0); end
      repeat (5) begin drive(1'b1, '0); drive(1'b0, '1); end
    end
    check_result("gapped", 10, 50);

    rv_count = 0;
    repeat (260) drive(1'b1, '0);
    check("timeout_unlocked", locked, 0);
    check("timeout_no_result", rv_count, 0);
    check_result("timeout_hold", 10, 50);

    square(5, 5, 3);
    check("relock", locked, 1);
    rv_count = 0;
    clear = 1'b1;
    drive(1'b1, '1);
    clear = 1'b0;
    check("clear_unlocks", locked, 0);
    repeat (4) drive(1'b1, '1);
    repeat (5) drive(1'b1, '0);
    check("clear_no_early_result", rv_count, 0);
    square(5, 5, 3);
    check("clear_results", rv_count, 3);
    check("clear_relock", locked, 1);
    check_result("clear", 10, 50);

    square(5, 5, 2);
    repeat (4) drive(1'b1, '1);
    rv_count = 0;
    reset = 1'b1;
    drive(1'b1, '1);
    reset = 1'b0;
    check("mid_reset_period", period, 0);
    check("mid_reset_duty", duty_cycle, 0);
    check("mid_reset_flags", {result_valid, locked, overrun}, 0);
    repeat (15) drive(1'b1, '0);
    check("mid_reset_no_result", rv_count, 0);

    rv_count = 0;
    repeat (40) drive(1'b1, 16'h8000);
    check("const_no_result", rv_count, 0);
    check("const_unlocked", locked, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
